rpu_dma_cmd_gen: RTL
====================

# rpu_dma_cmd_gen

Interconnect-side initiator for an RPU's DMA command port. Turns one byte-granular memory request (write or read, packet or header region) into the beat-level `dma_cmd_wr_*` / `dma_cmd_rd_*` command stream an RPU consumes. On reads it collects `dma_rd_resp_*` and returns the data as a framed stream. It sits between the DMA engine's request queue and one RPU slot's DMA inputs.

## Interface
- `DATA_WIDTH`, 128: beat width in bits; only 128 is supported.
- `STRB_WIDTH`, DATA_WIDTH/8: byte lanes per beat (16).
- `ADDR_WIDTH`, 26: byte address width of the RPU DMA port.
- `LEN_WIDTH`, 16: request length width in bytes.
- `clk`  in  1  clock for all logic.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  1  request valid.
- `req_ready`  out  1  request accepted when high with `req_valid`.
- `req_write`  in  1  1 = write, 0 = read.
- `req_hdr`  in  1  write targets the header region; ignored on reads.
- `req_addr`  in  ADDR_WIDTH  start byte address.
- `req_len`  in  LEN_WIDTH  length in bytes.
- `s_wr_data`  in  DATA_WIDTH  write payload, lane-aligned: lane i holds the byte at beat address + i.
- `s_wr_valid`  in  1  payload beat valid.
- `s_wr_ready`  out  1  payload beat consumed.
- `dma_cmd_wr_en`  out  1  packet-region write beat valid.
- `dma_cmd_hdr_wr_en`  out  1  header-region write beat valid.
- `dma_cmd_wr_addr`  out  26  beat address, 16-byte aligned.
- `dma_cmd_hdr_wr_addr`  out  24  `dma_cmd_wr_addr[23:0]`.
- `dma_cmd_wr_data`  out  128  write data.
- `dma_cmd_wr_strb`  out  16  byte enables.
- `dma_cmd_wr_last`  out  1  final beat of the request.
- `dma_cmd_wr_ready`  in  1  write beat accepted; shared by both write enables.
- `dma_cmd_rd_en`  out  1  read beat command valid.
- `dma_cmd_rd_addr`  out  26  read beat address, 16-byte aligned.
- `dma_cmd_rd_last`  out  1  final read command.
- `dma_cmd_rd_ready`  in  1  read command accepted.
- `dma_rd_resp_valid`  in  1  read response valid.
- `dma_rd_resp_data`  in  128  read response data.
- `dma_rd_resp_ready`  out  1  read response consumed.
- `m_rd_data`  out  128  returned beat.
- `m_rd_valid`  out  1  returned beat valid.
- `m_rd_last`  out  1  final returned beat.
- `m_rd_ready`  in  1  downstream ready.
- `busy`  out  1  high while not in IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, WR, RD.
- **IDLE**
  - `req_ready` = 1.
  - On acceptance, latch `write`, `hdr`, `base = addr & ~0xF`, `first_off = addr[3:0]`, `last_off = (addr+len-1)[3:0]`.
  - Compute `beats = (first_off + len + 15) >> 4`, LEN_WIDTH-3 bits wide.
  - Go to WR or RD.
  - `len == 0`: no commands issued; `done` pulses next cycle; stay IDLE.
- **WR**
  - Enable: `dma_cmd_hdr_wr_en` = `s_wr_valid` if hdr, else `dma_cmd_wr_en` = `s_wr_valid`. The other enable is 0.
  - Data and ready pass through: `dma_cmd_wr_data` = `s_wr_data`; `s_wr_ready` = `dma_cmd_wr_ready`.
  - Strobe: first beat masks lanes below `first_off`; last beat masks lanes above `last_off`; a single-beat request applies both masks; all other beats are 0xFFFF.
  - A beat transfers on `en && ready`. The beat address then advances by 16, modulo 2^ADDR_WIDTH.
  - `dma_cmd_wr_last` is high on beat index `beats-1`. Its transfer returns the FSM to IDLE.
- **RD**
  - Issues `beats` read commands with `dma_cmd_rd_last` on the final one. Address rules match WR.
  - Commands are issued independently of responses.
  - Responses pass through: `m_rd_valid` = `dma_rd_resp_valid`; `m_rd_data` = `dma_rd_resp_data`; `dma_rd_resp_ready` = `m_rd_ready`.
  - A response counter raises `m_rd_last` on response `beats-1`.
  - Leave RD only when all commands are issued and the last response has been transferred.
- Outside RD, `dma_rd_resp_ready` = 0 and `m_rd_valid` = 0. Stray responses stall and are never dropped.
- `busy` = (state != IDLE).

## Timing
- Reset (async assert):
  - State returns to IDLE; counters clear.
  - Every output is 0, including `req_ready`, `busy` and `done`.
  - `req_ready` rises on the first clock edge after `rst_n` deasserts.
- Reset mid-request aborts the transfer. No partial-beat completion and no `done`.
- Request accepted at edge T → first command valid in cycle T+1.
- Command-side throughput: 1 beat/cycle under continuous ready.
- Final write transfer at edge T → `done` high and `req_ready` high in cycle T+1.
- Final read response transfer at edge T → `done` high and `req_ready` high in cycle T+1.
- Minimum spacing between requests: 1 IDLE cycle.
- Command outputs must hold stable while `en` (`rd_en`) is high and ready is low.

## Test plan
- Aligned write, addr 0x1000, len 32, ready always high → `dma_cmd_wr_en` beats at 0x1000 and 0x1010, strb 0xFFFF and 0xFFFF, `last` on the 2nd beat, `done` one cycle later.
- Unaligned write, addr 0x1003, len 20 → 2 beats, strb 0xFFF8 then 0x007F. Addr 0x2005, len 3 → 1 beat, strb 0x00E0, `last` = 1.
- Header write, `req_hdr` = 1, addr 0x000040, len 16, `dma_cmd_wr_ready` low for 3 cycles → `dma_cmd_hdr_wr_en` held with stable addr 0x000040 and `hdr_wr_addr` 0x000040. `dma_cmd_wr_en` stays 0 throughout.
- Read, addr 0x3000, len 48, `rd_ready` toggling, responses arriving with `m_rd_ready` 50% backpressure → 3 commands (`rd_last` on 0x3020), 3 `m_rd` beats with `m_rd_last` on the 3rd, `done` after the 3rd beat transfers.
- Wrap and zero length: write addr 0x3FFFFF0, len 32 → addrs 0x3FFFFF0 then 0x0000000. Len 0 → no commands, `done` pulse one cycle after acceptance.
- Reset mid-write: drop `rst_n` after beat 1 of 4 → all outputs 0 immediately. After release, a fresh addr 0x0, len 16 request completes normally.

Source files
------------

// File: rtl/rpu_dma_cmd_gen_if.sv
// rpu_dma_cmd_gen_if: request, write payload, RPU DMA command/response and read-return bundle
// master: the command generator; slave: request queue, payload source, RPU slot and read sink.
// req_*: byte-granular request; s_wr_*: lane-aligned write payload;
// dma_cmd_wr_*/dma_cmd_hdr_wr_*: write beats; dma_cmd_rd_*: read beat commands;
// dma_rd_resp_*: RPU read responses; m_rd_*: returned read stream; busy/done: status.
interface rpu_dma_cmd_gen_if #(
  parameter int DATA_WIDTH = 128,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int ADDR_WIDTH = 26,
  parameter int LEN_WIDTH  = 16
);
  logic                  req_valid, req_ready, req_write, req_hdr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LEN_WIDTH-1:0]  req_len;
  logic [DATA_WIDTH-1:0] s_wr_data;
  logic                  s_wr_valid, s_wr_ready;
  logic                  dma_cmd_wr_en, dma_cmd_hdr_wr_en, dma_cmd_wr_last, dma_cmd_wr_ready;
  logic [ADDR_WIDTH-1:0] dma_cmd_wr_addr;
  logic [23:0]           dma_cmd_hdr_wr_addr;
  logic [DATA_WIDTH-1:0] dma_cmd_wr_data;
  logic [STRB_WIDTH-1:0] dma_cmd_wr_strb;
  logic                  dma_cmd_rd_en, dma_cmd_rd_last, dma_cmd_rd_ready;
  logic [ADDR_WIDTH-1:0] dma_cmd_rd_addr;
  logic                  dma_rd_resp_valid, dma_rd_resp_ready;
  logic [DATA_WIDTH-1:0] dma_rd_resp_data;
  logic [DATA_WIDTH-1:0] m_rd_data;
  logic                  m_rd_valid, m_rd_last, m_rd_ready;
  logic                  busy, done;
  modport master (
    input  req_valid, req_write, req_hdr, req_addr, req_len, s_wr_data, s_wr_valid,
           dma_cmd_wr_ready, dma_cmd_rd_ready, dma_rd_resp_valid, dma_rd_resp_data, m_rd_ready,
    output req_ready, s_wr_ready, dma_cmd_wr_en, dma_cmd_hdr_wr_en, dma_cmd_wr_addr,
           dma_cmd_hdr_wr_addr, dma_cmd_wr_data, dma_cmd_wr_strb, dma_cmd_wr_last,
           dma_cmd_rd_en, dma_cmd_rd_addr, dma_cmd_rd_last, dma_rd_resp_ready,
           m_rd_data, m_rd_valid, m_rd_last, busy, done
  );
  modport slave (
    output req_valid, req_write, req_hdr, req_addr, req_len, s_wr_data, s_wr_valid,
           dma_cmd_wr_ready, dma_cmd_rd_ready, dma_rd_resp_valid, dma_rd_resp_data, m_rd_ready,
    input  req_ready, s_wr_ready, dma_cmd_wr_en, dma_cmd_hdr_wr_en, dma_cmd_wr_addr,
           dma_cmd_hdr_wr_addr, dma_cmd_wr_data, dma_cmd_wr_strb, dma_cmd_wr_last,
           dma_cmd_rd_en, dma_cmd_rd_addr, dma_cmd_rd_last, dma_rd_resp_ready,
           m_rd_data, m_rd_valid, m_rd_last, busy, done
  );
endinterface

// File: rtl/rpu_dma_cmd_gen.sv
// rpu_dma_cmd_gen: turns a byte-granular request into RPU DMA beat commands and returns read data
// clk/rst_n: clock and asynchronous active-low reset.
// io (master modport of rpu_dma_cmd_gen_if): request, write payload, command, response and status signals.
module rpu_dma_cmd_gen #(
  parameter int DATA_WIDTH = 128,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int ADDR_WIDTH = 26,
  parameter int LEN_WIDTH  = 16
) (
  input logic               clk,
  input logic               rst_n,
  rpu_dma_cmd_gen_if.master io
);
  localparam int CW = LEN_WIDTH - 3;
  localparam logic [STRB_WIDTH-1:0] ONES = '1;
  typedef enum logic [1:0] {IDLE, WR, RD} state_t;
  state_t                state_q, state_d;
  logic                  up_q, up_d, hdr_q, hdr_d, done_q, done_d;
  logic                  cmd_done_q, cmd_done_d, rsp_done_q, rsp_done_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            first_off_q, first_off_d, last_off_q, last_off_d;
  logic [CW-1:0]         last_idx_q, last_idx_d, cmd_idx_q, cmd_idx_d, rsp_idx_q, rsp_idx_d;
  logic [CW-1:0]         beats;
  logic [STRB_WIDTH-1:0] lo_mask, hi_mask;
  logic                  wr, rd, rd_cmd, rsp_on, accept, wr_en, wr_xfer, rd_xfer, rsp_xfer;
  logic                  cmd_last, rsp_last;
  assign wr       = state_q == WR;
  assign rd       = state_q == RD;
  assign rd_cmd   = rd && !cmd_done_q;
  // once the final response is taken, later responses stall instead of being consumed
  assign rsp_on   = rd && !rsp_done_q;
  assign cmd_last = cmd_idx_q == last_idx_q;
  assign rsp_last = rsp_idx_q == last_idx_q;
  assign accept   = io.req_ready && io.req_valid;
  assign wr_en    = wr && io.s_wr_valid;
  assign wr_xfer  = wr_en && io.dma_cmd_wr_ready;
  assign rd_xfer  = rd_cmd && io.dma_cmd_rd_ready;
  assign rsp_xfer = rsp_on && io.dma_rd_resp_valid && io.m_rd_ready;
  // widened by one bit so the +15 round-up cannot overflow before the shift
  assign beats    = CW'(({1'b0, io.req_len} + (LEN_WIDTH+1)'(io.req_addr[3:0]) + (LEN_WIDTH+1)'(15)) >> 4);
  assign lo_mask  = ONES << first_off_q;
  assign hi_mask  = ONES >> (4'd15 - last_off_q);
  // req_ready stays low until the first edge after reset release
  assign io.req_ready           = up_q && state_q == IDLE;
  assign io.busy                = state_q != IDLE;
  assign io.done                = done_q;
  assign io.s_wr_ready          = wr && io.dma_cmd_wr_ready;
  assign io.dma_cmd_wr_en       = wr_en && !hdr_q;
  assign io.dma_cmd_hdr_wr_en   = wr_en && hdr_q;
  assign io.dma_cmd_wr_addr     = wr ? addr_q : '0;
  assign io.dma_cmd_hdr_wr_addr = wr ? addr_q[23:0] : 24'h0;
  assign io.dma_cmd_wr_data     = wr ? io.s_wr_data : {DATA_WIDTH{1'b0}};
  assign io.dma_cmd_wr_strb     = wr ? ((cmd_idx_q == '0 ? lo_mask : ONES) & (cmd_last ? hi_mask : ONES)) : '0;
  assign io.dma_cmd_wr_last     = wr && cmd_last;
  assign io.dma_cmd_rd_en       = rd_cmd;
  assign io.dma_cmd_rd_addr     = rd_cmd ? addr_q : '0;
  assign io.dma_cmd_rd_last     = rd_cmd && cmd_last;
  assign io.m_rd_valid          = rsp_on && io.dma_rd_resp_valid;
  assign io.m_rd_data           = rsp_on ? io.dma_rd_resp_data : {DATA_WIDTH{1'b0}};
  assign io.m_rd_last           = rsp_on && rsp_last;
  assign io.dma_rd_resp_ready   = rsp_on && io.m_rd_ready;
  always_comb begin
    state_d     = state_q;
    up_d        = 1'b1;
    hdr_d       = hdr_q;
    done_d      = 1'b0;
    cmd_done_d  = cmd_done_q;
    rsp_done_d  = rsp_done_q;
    addr_d      = addr_q;
    first_off_d = first_off_q;
    last_off_d  = last_off_q;
    last_idx_d  = last_idx_q;
    cmd_idx_d   = cmd_idx_q;
    rsp_idx_d   = rsp_idx_q;
    if (accept && io.req_len == '0) done_d = 1'b1;
    else if (accept) begin
      state_d     = io.req_write ? WR : RD;
      hdr_d       = io.req_hdr;
      addr_d      = {io.req_addr[ADDR_WIDTH-1:4], 4'h0};
      first_off_d = io.req_addr[3:0];
      last_off_d  = io.req_addr[3:0] + io.req_len[3:0] - 4'd1;
      last_idx_d  = beats - CW'(1);
      cmd_idx_d   = '0;
      rsp_idx_d   = '0;
      cmd_done_d  = 1'b0;
      rsp_done_d  = 1'b0;
    end
    if (wr_xfer || rd_xfer) begin
      addr_d    = addr_q + ADDR_WIDTH'(16);
      cmd_idx_d = cmd_idx_q + CW'(1);
    end
    if (rd_xfer && cmd_last) cmd_done_d = 1'b1;
    if (rsp_xfer) begin
      rsp_idx_d  = rsp_idx_q + CW'(1);
      rsp_done_d = rsp_last;
    end
    if ((wr_xfer && cmd_last) || (rd && cmd_done_d && rsp_done_d)) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      up_q        <= 1'b0;
      hdr_q       <= 1'b0;
      done_q      <= 1'b0;
      cmd_done_q  <= 1'b0;
      rsp_done_q  <= 1'b0;
      addr_q      <= '0;
      first_off_q <= '0;
      last_off_q  <= '0;
      last_idx_q  <= '0;
      cmd_idx_q   <= '0;
      rsp_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      up_q        <= up_d;
      hdr_q       <= hdr_d;
      done_q      <= done_d;
      cmd_done_q  <= cmd_done_d;
      rsp_done_q  <= rsp_done_d;
      addr_q      <= addr_d;
      first_off_q <= first_off_d;
      last_off_q  <= last_off_d;
      last_idx_q  <= last_idx_d;
      cmd_idx_q   <= cmd_idx_d;
      rsp_idx_q   <= rsp_idx_d;
    end
endmodule
